// File: rtl/trigger_scheduler_if.sv
// Bus bundle for trigger_scheduler: run/config controls in,
// tick/grant/status out.
interface trigger_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               en;
    logic [CNT_W-1:0]   period_in;
    logic               period_load;
    logic [NUM_REQ-1:0] req;
    logic               tick;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic               busy;
    logic               cfg_err;

    modport master (
        output en, period_in, period_load, req,
        input  tick, grant, grant_id, busy, cfg_err
    );

    modport slave (
        input  en, period_in, period_load, req,
        output tick, grant, grant_id, busy, cfg_err
    );
endinterface

// File: rtl/trigger_scheduler.sv
// Periodic tick generator with a round-robin grant
// handed to one pending requester on every tick.
module trigger_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 8,
    parameter int PERIOD_DEF = 2
) (
    input  logic clk,
    input  logic rst,
    trigger_scheduler_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   shd_q, shd_d;
    logic               shd_vld_q, shd_vld_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic               tick_q, tick_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic               busy_q, busy_d;
    logic               cfg_err_q, cfg_err_d;

    logic               load_ok;
    logic               wrap;
    logic               found;
    logic [IDW-1:0]     sel;

    assign load_ok = bus.period_load && (bus.period_in != '0);
    assign wrap    = (cnt_q == per_q - 1'b1);

    // Round-robin search: first set req bit after ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        shd_d     = shd_q;
        shd_vld_d = shd_vld_q;
        ptr_d     = ptr_q;
        tick_d    = 1'b0;
        grant_d   = '0;
        gid_d     = gid_q;
        busy_d    = busy_q;
        cfg_err_d = bus.period_load && (bus.period_in == '0);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (load_ok) begin
                    per_d     = bus.period_in;
                    shd_vld_d = 1'b0;
                end
                if (bus.en) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    if (load_ok) begin
                        shd_d     = bus.period_in;
                        shd_vld_d = 1'b1;
                    end
                end else if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (load_ok) begin
                        per_d     = bus.period_in;
                        shd_vld_d = 1'b0;
                    end else if (shd_vld_q) begin
                        per_d     = shd_q;
                        shd_vld_d = 1'b0;
                    end
                    if (found) begin
                        grant_d      = '0;
                        grant_d[sel] = 1'b1;
                        gid_d        = sel;
                        ptr_d        = sel;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (load_ok) begin
                        shd_d     = bus.period_in;
                        shd_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            per_q     <= CNT_W'(PERIOD_DEF);
            shd_q     <= '0;
            shd_vld_q <= 1'b0;
            ptr_q     <= IDW'(NUM_REQ - 1);
            tick_q    <= 1'b0;
            grant_q   <= '0;
            gid_q     <= '0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            shd_q     <= shd_d;
            shd_vld_q <= shd_vld_d;
            ptr_q     <= ptr_d;
            tick_q    <= tick_d;
            grant_q   <= grant_d;
            gid_q     <= gid_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.grant    = grant_q;
    assign bus.grant_id = gid_q;
    assign bus.busy     = busy_q;
    assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_trigger_scheduler.sv
// Directed bench for trigger_scheduler; expected values
// are hand-derived edge by edge from the intended behaviour.
module tb_trigger_scheduler;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    trigger_scheduler_if #(.NUM_REQ(4), .CNT_W(8)) bus ();

    trigger_scheduler #(
        .NUM_REQ(4),
        .CNT_W(8),
        .PERIOD_DEF(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic t,
                       input logic [3:0] g, input logic [1:0] id,
                       input logic b, input logic ce);
        logic [8:0] got;
        logic [8:0] exp;
        got = {bus.tick, bus.grant, bus.grant_id, bus.busy, bus.cfg_err};
        exp = {t, g, id, b, ce};
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got tick/grant/id/busy/err=%b expected %b",
                   tag, got, exp);
        end
    endtask

    initial begin
        tests           = 0;
        fails           = 0;
        rst             = 1'b0;
        bus.en          = 1'b0;
        bus.period_in   = '0;
        bus.period_load = 1'b0;
        bus.req         = '0;
        #3;
        chk("reset", 0, 4'h0, 0, 0, 0);
        step(2);
        rst = 1'b1;
        step();
        chk("idle", 0, 4'h0, 0, 0, 0);

        // round robin over all four requesters, period 2
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        step(); chk("run_enter", 0, 4'h0, 0, 1, 0);
        step(); chk("e1", 0, 4'h0, 0, 1, 0);
        step(); chk("g0", 1, 4'h1, 0, 1, 0);
        step(); chk("e3", 0, 4'h0, 0, 1, 0);
        step(); chk("g1", 1, 4'h2, 1, 1, 0);
        step(2); chk("g2", 1, 4'h4, 2, 1, 0);
        step(2); chk("g3", 1, 4'h8, 3, 1, 0);
        step(2); chk("g0_again", 1, 4'h1, 0, 1, 0);

        // sparse request pattern alternates 1 and 3
        bus.req = 4'b1010;
        step(2); chk("alt1", 1, 4'h2, 1, 1, 0);
        step(2); chk("alt3", 1, 4'h8, 3, 1, 0);
        step(2); chk("alt1b", 1, 4'h2, 1, 1, 0);

        // mid-period load is deferred to the next wrap
        bus.period_load = 1'b1;
        bus.period_in   = 8'd5;
        step(); chk("shadow_load", 0, 4'h0, 1, 1, 0);
        bus.period_load = 1'b0;
        step(); chk("old_spacing", 1, 4'h8, 3, 1, 0);
        bus.req = 4'b0000;
        step(4); chk("new_gap", 0, 4'h0, 3, 1, 0);
        step(); chk("per5_tick_noreq", 1, 4'h0, 3, 1, 0);

        // zero period is rejected
        bus.period_load = 1'b1;
        bus.period_in   = 8'd0;
        step(); chk("cfg_err", 0, 4'h0, 3, 1, 1);
        bus.period_load = 1'b0;
        step(); chk("cfg_err_pulse", 0, 4'h0, 3, 1, 0);
        step(2); chk("per5_kept_gap", 0, 4'h0, 3, 1, 0);

        // load on the wrap cycle takes effect at once
        bus.period_load = 1'b1;
        bus.period_in   = 8'd3;
        step(); chk("per5_kept_tick", 1, 4'h0, 3, 1, 0);
        bus.period_load = 1'b0;
        bus.req         = 4'b0001;
        step(2); chk("per3_gap", 0, 4'h0, 3, 1, 0);
        step(); chk("per3_tick", 1, 4'h1, 0, 1, 0);

        // stop mid-period, then restart with per=1 loaded
        step(); chk("pre_stop", 0, 4'h0, 0, 1, 0);
        bus.en = 1'b0;
        step(); chk("stopped", 0, 4'h0, 0, 0, 0);
        bus.req = 4'b1111;
        step(2); chk("idle_quiet", 0, 4'h0, 0, 0, 0);
        bus.en          = 1'b1;
        bus.period_load = 1'b1;
        bus.period_in   = 8'd1;
        step(); chk("restart", 0, 4'h0, 0, 1, 0);
        bus.period_load = 1'b0;
        step(); chk("per1_a", 1, 4'h2, 1, 1, 0);
        step(); chk("per1_b", 1, 4'h4, 2, 1, 0);
        step(); chk("per1_c", 1, 4'h8, 3, 1, 0);

        // asynchronous reset mid-run
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", 0, 4'h0, 0, 0, 0);
        step(2);
        chk("rst_held", 0, 4'h0, 0, 0, 0);
        rst = 1'b1;
        step(); chk("rst_run", 0, 4'h0, 0, 1, 0);
        step(); chk("rst_e1", 0, 4'h0, 0, 1, 0);
        step(); chk("rst_g0", 1, 4'h1, 0, 1, 0);
        step(); chk("rst_e3", 0, 4'h0, 0, 1, 0);
        step(); chk("rst_g1", 1, 4'h2, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
